// File: rtl/decoder_sweep_ctrl.sv
// Sweep controller for the 2-to-4 enabled decoder: walks {en,a} through all
// eight codes with a programmable dwell and checks the decoder's one-hot y.
module decoder_sweep_ctrl #(
  parameter int unsigned DIV_WIDTH     = 8,
  parameter int unsigned ERR_CNT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [DIV_WIDTH-1:0]     div,
  input  logic [3:0]               y_in,
  output logic [1:0]               a,
  output logic                     en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [2:0]               err_step
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [2:0]           step;
  logic [DIV_WIDTH-1:0] dwell;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 cont_q;

  logic [3:0]           y_exp_c;
  logic                 check_c;
  logic                 mismatch_c;

  // step is held at zero outside RUN, so it can drive the decoder directly
  assign en = step[2];
  assign a  = step[1:0];

  // Expected one-hot pattern and the end-of-dwell check strobe
  always_comb begin
    y_exp_c    = 4'b0000;
    check_c    = 1'b0;
    mismatch_c = 1'b0;
    if (step[2]) begin
      y_exp_c = 4'(4'b0001 << step[1:0]);
    end
    if ((state == RUN) && (dwell == div_q)) begin
      check_c = 1'b1;
    end
    if (check_c && (y_in != y_exp_c)) begin
      mismatch_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= 3'd0;
      dwell    <= '0;
      div_q    <= '0;
      cont_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      err_step <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            div_q    <= div;
            cont_q   <= continuous;
            err      <= 1'b0;
            err_cnt  <= '0;
            err_step <= 3'd0;
            step     <= 3'd0;
            dwell    <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // The check of this cycle still lands even when stop is also high
          if (mismatch_c) begin
            err <= 1'b1;
            if (err_cnt != '1) begin
              err_cnt <= ERR_CNT_WIDTH'(err_cnt + 1'b1);
            end
            if (!err) begin
              err_step <= step;
            end
          end
          if (stop) begin
            step  <= 3'd0;
            dwell <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (check_c) begin
            dwell <= '0;
            if (step == 3'd7) begin
              done <= 1'b1;
              step <= 3'd0;
              if (!cont_q) begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              step <= 3'(step + 3'd1);
            end
          end else begin
            dwell <= DIV_WIDTH'(dwell + 1'b1);
          end
        end
        default: begin
          state <= IDLE;
          step  <= 3'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_sweep_ctrl.sv
// Bench for decoder_sweep_ctrl: a behavioural decoder (with fault modes) closes
// the loop, and a time-based model predicts every cycle of each sweep.
module tb_decoder_sweep_ctrl;

  localparam int unsigned DIV_WIDTH     = 8;
  localparam int unsigned ERR_CNT_WIDTH = 4;
  localparam int          CNT_MAX       = (1 << ERR_CNT_WIDTH) - 1;

  typedef struct packed {
    logic [2:0]               ea;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [ERR_CNT_WIDTH-1:0] cnt;
    logic [2:0]               estep;
  } obs_t;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic                     stop;
  logic                     continuous;
  logic [DIV_WIDTH-1:0]     div;
  logic [3:0]               y_in;
  logic [1:0]               a;
  logic                     en;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic [2:0]               err_step;

  int         checks;
  int         errors;
  int         fmode;
  logic [2:0] fstep;
  logic [3:0] fval;

  decoder_sweep_ctrl #(
    .DIV_WIDTH    (DIV_WIDTH),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .continuous(continuous),
    .div       (div),
    .y_in      (y_in),
    .a         (a),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_step  (err_step)
  );

  always #5 clk = ~clk;

  // Decoder under test: ideal, one faulty code replaced by fv, or stuck at 1111
  function automatic logic [3:0] dec_y(logic [2:0] ea, int fm, logic [2:0] fs, logic [3:0] fv);
    logic [3:0] ideal;
    ideal = 4'b0000;
    if (ea[2]) ideal[ea[1:0]] = 1'b1;
    if (fm == 1 && ea == fs) return fv;
    if (fm == 2) return 4'b1111;
    return ideal;
  endfunction

  always_comb y_in = dec_y({en, a}, fmode, fstep, fval);

  // Cycle c (counted from the first RUN cycle) belongs to the sweep
  function automatic bit in_run(int c, int dd, bit cont, int stop_k);
    return ((stop_k < 0) || (c <= stop_k)) && (cont || (c < 8 * dd));
  endfunction

  // Expected observation k cycles after the start edge
  function automatic obs_t model(int k, int d, bit cont, int fm, logic [2:0] fs,
                                 logic [3:0] fv, int stop_k);
    obs_t       e;
    int         dd;
    int         cnt;
    logic [2:0] s;
    e   = '0;
    dd  = d + 1;
    cnt = 0;
    for (int c = 0; c < k; c++) begin
      if (in_run(c, dd, cont, stop_k) && (c % dd) == dd - 1) begin
        s = 3'((c / dd) % 8);
        if (dec_y(s, fm, fs, fv) != dec_y(s, 0, fs, fv)) begin
          cnt++;
          if (!e.err) e.estep = s;
          e.err = 1'b1;
        end
      end
    end
    e.cnt  = (cnt > CNT_MAX) ? ERR_CNT_WIDTH'(CNT_MAX) : ERR_CNT_WIDTH'(cnt);
    e.busy = in_run(k, dd, cont, stop_k);
    e.ea   = e.busy ? 3'((k / dd) % 8) : 3'd0;
    e.done = (k > 0) && (k % (8 * dd) == 0) && in_run(k - 1, dd, cont, stop_k)
             && (k - 1 != stop_k);
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t g;
    g.ea    = {en, a};
    g.busy  = busy;
    g.done  = done;
    g.err   = err;
    g.cnt   = err_cnt;
    g.estep = err_step;
    return g;
  endfunction

  // One sweep from start, compared cycle by cycle; optionally pokes start/div/continuous while running
  task automatic test_sweep(input string name, input int d, input bit cont, input int fm,
                            input logic [2:0] fs, input logic [3:0] fv, input int stop_k,
                            input int ncyc, input bit poke);
    obs_t e;
    obs_t g;
    fmode = fm;
    fstep = fs;
    fval  = fv;
    @(negedge clk);
    div        = DIV_WIDTH'(d);
    continuous = cont;
    start      = 1'b1;
    stop       = 1'b0;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      e = model(k, d, cont, fm, fs, fv, stop_k);
      g = observe();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s k=%0d got ea=%b busy=%b done=%b err=%b cnt=%0d step=%b exp ea=%b busy=%b done=%b err=%b cnt=%0d step=%b",
                 name, k, g.ea, g.busy, g.done, g.err, g.cnt, g.estep,
                 e.ea, e.busy, e.done, e.err, e.cnt, e.estep);
      end
      start = (poke && e.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (poke) begin
        div        = DIV_WIDTH'($urandom);
        continuous = 1'($urandom_range(0, 1));
      end
      stop = (k == stop_k);
    end
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    obs_t g;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    g = observe();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL reset_held got %h exp 0", g);
    end
    reset = 1'b0;
    @(negedge clk);
    g = observe();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL reset_release got %h exp 0", g);
    end
  endtask

  task automatic test_single_sweep();
    test_sweep("single", 0, 1'b0, 0, 3'd0, 4'd0, -1, 12, 1'b0);
  endtask

  task automatic test_dwell();
    test_sweep("dwell", 3, 1'b0, 0, 3'd0, 4'd0, -1, 36, 1'b0);
  endtask

  task automatic test_fault();
    int d;
    d = int'($urandom_range(0, 3));
    test_sweep("fault", d, 1'b0, 1, 3'b110, 4'b0000, -1, 8 * (d + 1) + 4, 1'b0);
    test_sweep("fault_clear", d, 1'b0, 0, 3'd0, 4'd0, -1, 3, 1'b0);
  endtask

  task automatic test_cont_stop();
    test_sweep("cont_stop", 1, 1'b1, 0, 3'd0, 4'd0, 16 + 5 * 2, 30, 1'b0);
  endtask

  task automatic test_saturation();
    test_sweep("saturate", 0, 1'b1, 2, 3'd0, 4'd0, 29, 33, 1'b0);
  endtask

  task automatic test_back_to_back();
    int  d;
    bit  cont;
    int  stop_k;
    int  ncyc;
    for (int i = 0; i < 6; i++) begin
      d    = int'($urandom_range(0, 4));
      cont = 1'($urandom_range(0, 1));
      if (cont) begin
        stop_k = int'($urandom_range(3, 16 * (d + 1)));
        ncyc   = stop_k + 4;
      end else begin
        stop_k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8 * (d + 1) - 1)) : -1;
        ncyc   = 8 * (d + 1) + 4;
      end
      test_sweep("random", d, cont, int'($urandom_range(0, 2)), 3'($urandom),
                 4'($urandom), stop_k, ncyc, 1'b1);
    end
  endtask

  task automatic test_start_stop_idle();
    obs_t g;
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      g = observe();
      checks++;
      if (g.busy !== 1'b0 || g.ea !== 3'd0 || g.done !== 1'b0) begin
        errors++;
        $display("FAIL start_stop_idle k=%0d got busy=%b ea=%b done=%b exp 0 0 0",
                 k, g.busy, g.ea, g.done);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t g;
    fmode = 2;
    @(negedge clk);
    div        = DIV_WIDTH'(1);
    continuous = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (int'($urandom_range(4, 12))) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    g = observe();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h exp 0", g);
    end
    reset = 1'b0;
    fmode = 0;
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    div        = '0;
    fmode      = 0;
    fstep      = 3'd0;
    fval       = 4'd0;
    checks     = 0;
    errors     = 0;
    test_reset();
    test_single_sweep();
    test_dwell();
    test_fault();
    test_cont_stop();
    test_saturation();
    test_start_stop_idle();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
